// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: locks byte alignment on repeated COM symbols, then delivers data bytes.
// Optional macro RX_ERR_CNT_EN adds a saturating false-lock counter output (err_cnt).
module serial_paralelo_rx #(
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned COM_COUNT  = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
`ifdef RX_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t     state_q;
  logic [6:0] sr_q;
  logic [2:0] bit_cnt_q;
  logic [3:0] com_cnt_q;
  logic [3:0] com_cnt_d;
  logic [7:0] win;
  logic       win_is_com;
  logic       boundary;

  // Window always includes the bit arriving on this edge, so a byte is registered on its last bit.
  assign win        = {sr_q, data_in};
  assign win_is_com = (win == COM_SYMBOL);
  assign boundary   = (bit_cnt_q == 3'd7);

  always_comb begin
    com_cnt_d = com_cnt_q;
    if (com_cnt_q < 4'(COM_COUNT)) com_cnt_d = com_cnt_q + 4'd1;
  end

`ifdef RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state_q   <= SEARCH;
      sr_q      <= 7'd0;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
`ifdef RX_ERR_CNT_EN
      err_cnt_q <= 8'd0;
`endif
    end else begin
      sr_q <= win[6:0];
      case (state_q)
        SEARCH: begin
          if (win_is_com) begin
            state_q   <= ALIGN;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd1;
          end
        end
        ALIGN: begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (boundary) begin
            if (win_is_com) begin
              com_cnt_q <= com_cnt_d;
              if (com_cnt_d == 4'(COM_COUNT)) begin
                state_q <= ACTIVE;
                active  <= 1'b1;
              end
            end else begin
              // False lock: drop back and hunt again from the next edge.
              state_q   <= SEARCH;
              com_cnt_q <= 4'd0;
`ifdef RX_ERR_CNT_EN
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
`endif
            end
          end
        end
        ACTIVE: begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (boundary) begin
            if (win_is_com) begin
              valid_out <= 1'b0;
            end else begin
              data_out  <= win;
              valid_out <= 1'b1;
            end
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

endmodule

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
- Receive-side deserializer for the lane link. Takes the 1-bit serial stream from the transmit serializer and rebuilds 8-bit bytes for the 8→32 mux input.
- Locks byte alignment on the COM symbol (0xBC) sent during idle. Declares the lane active after COM_COUNT consecutive aligned COMs.
- Once active, delivers non-COM bytes with a valid flag.

Parameters:
- COM_SYMBOL, 8'hBC, comma/idle symbol used for alignment; never delivered as data.
- COM_COUNT, 4, consecutive aligned COMs needed to go ACTIVE (range 2..15).

Ports:
- clk_32f  input  1  bit clock; one serial bit per rising edge.
- reset_L  input  1  synchronous, active-low reset.
- data_in  input  1  serial bit, MSB of each byte first.
- data_out  output  8  last delivered byte.
- valid_out  output  1  data_out holds a valid data byte.
- active  output  1  lane aligned and active.

Behaviour:
- Everything updates on the rising edge of clk_32f only. Reset applies when reset_L=0 at an edge. There is no asynchronous path.
- Reset values: sr=0, bit_cnt=0, com_cnt=0, state=SEARCH, data_out=8'h00, valid_out=0, active=0.
- A reset during any state, including mid-byte, takes effect at that edge and discards partial bytes and alignment.
- Shift register: sr <= {sr[6:0], data_in} every cycle out of reset. Window w = {sr[6:0], data_in}, combinational, i.e. the 8 most recent bits including the current one.
- States: SEARCH, ALIGN, ACTIVE (2-bit encoding).
- SEARCH:
  - Tests w on every edge.
  - If w==COM_SYMBOL: go to ALIGN, bit_cnt<=0, com_cnt<=1.
  - Otherwise stay in SEARCH.
- ALIGN and ACTIVE:
  - bit_cnt increments mod 8 each edge.
  - A byte boundary is an edge with bit_cnt==7; at that edge w is an aligned byte.
- ALIGN, at a boundary:
  - w==COM_SYMBOL: com_cnt+1. If the new count == COM_COUNT, go to ACTIVE and set active<=1 at that same edge.
  - w!=COM_SYMBOL: go to SEARCH, com_cnt<=0. No re-test of w on that edge.
  - valid_out stays 0 throughout ALIGN.
- ACTIVE, at a boundary:
  - w!=COM_SYMBOL: data_out<=w, valid_out<=1.
  - w==COM_SYMBOL: valid_out<=0, data_out holds its old value.
- Output hold: data_out and valid_out are held between boundaries, 8 cycles each.
- Latency: outputs are registered at the same edge that samples the byte's last bit.
- ACTIVE is sticky until reset. A COM pattern straddling a byte boundary while in ACTIVE or ALIGN is ignored; no realignment.
- com_cnt is 4 bits and saturates at COM_COUNT.
- Simultaneous reset and boundary: reset wins.

Optional Feature:
- Macro RX_ERR_CNT_EN.
- Defined: adds output port err_cnt [7:0], reset 0.
  - Increments at each ALIGN→SEARCH fallback (false lock).
  - Saturates at 255 and clears only on reset.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- reset_L=0 for 3 cycles while data_in toggles → data_out=0x00, valid_out=0, active=0 at every edge.
- 3 junk bits 101, then 4×0xBC, then 0x5A, all MSB-first:
  - active=1 from the edge of the last bit of the 4th 0xBC.
  - valid_out=1 and data_out=0x5A exactly 8 edges later, held 8 cycles.
- 3×0xBC then 0x12 → return to SEARCH, active stays 0, valid_out stays 0; err_cnt=1 when RX_ERR_CNT_EN is defined. A following 4×0xBC then locks.
- In ACTIVE, send 0x33, 0xBC, 0x44:
  - valid_out=1/0x33, then valid_out=0 with data_out still 0x33, then valid_out=1/0x44.
- In ACTIVE, send 0x0B then 0xC0 (0xBC straddles the boundary) → delivered as 0x0B then 0xC0, no realignment.
- reset_L=0 for one edge mid-byte in ACTIVE:
  - All outputs return to reset values at that edge.
  - Relock needs 4 fresh COMs; data sent before the relock is not delivered.
